// File: rtl/gpcfg_access_arb_if.sv
// gpcfg_access_arb_if
//   Bundles the two requester channels, the gpcfg bank access signals and
//   the busy flag for gpcfg_access_arb.
//   slave  : arbiter view (requests and mux_rdata in; acks, response and bank
//            strobes out).
//   master : requester/bank view (the mirror image).
//   Ports carried: req0/1, we0/1, addr0/1, wdata0/1, ack0/1, rsp_err,
//   rsp_rdata, cfg_addr, cfg_wr, cfg_wdata, cfg_rd, mux_rdata, busy.
interface gpcfg_access_arb_if #(
   parameter int AW = 10
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [31:0]   wdata0;
   logic [31:0]   wdata1;
   logic          ack0;
   logic          ack1;
   logic          rsp_err;
   logic [31:0]   rsp_rdata;
   logic [AW-1:0] cfg_addr;
   logic          cfg_wr;
   logic [31:0]   cfg_wdata;
   logic          cfg_rd;
   logic [31:0]   mux_rdata;
   logic          busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mux_rdata,
      output ack0, ack1, rsp_err, rsp_rdata, cfg_addr, cfg_wr, cfg_wdata,
             cfg_rd, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mux_rdata,
      input  ack0, ack1, rsp_err, rsp_rdata, cfg_addr, cfg_wr, cfg_wdata,
             cfg_rd, busy
   );
endinterface

// File: rtl/gpcfg_access_arb.sv
// gpcfg_access_arb
//   Arbitrates the AHB host front-end (req0) and the debug/mailbox agent
//   (req1) for the gpcfg register bank, sequences one bank access per grant
//   and returns the result with a one-cycle ack to the granted requester.
//
//   Ports:
//     hclk     clock
//     hresetn  asynchronous active-low reset
//     bus      gpcfg_access_arb_if.slave (requester channels, bank strobes,
//              registered read-mux data, busy)
//
//   Build option: define GPCFG_ARB_FIXED_PRIO_EN for fixed priority (req0
//   always wins a tie). Default is round-robin between the two requesters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; arbitrate and latch the winner's fields
//   RD    | cfg_rd high for one cycle (valid_rd into the read OR-mux)
//   RWAIT | mux presents registered read data; capture it
//   WR    | cfg_wr high for one cycle
//   DONE  | ack to the granted requester with rsp_err / rsp_rdata
module gpcfg_access_arb #(
   parameter int NUM_REGS = 1024,
   parameter int AW       = 10
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   gpcfg_access_arb_if.slave      bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD    = 3'd1;
   localparam logic [2:0] RWAIT = 3'd2;
   localparam logic [2:0] WR    = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]    state;
   logic          gnt_id;
   logic [AW-1:0] lat_addr;
   logic [31:0]   lat_wdata;
   logic          err_pend;
   logic [31:0]   rdata_q;
`ifndef GPCFG_ARB_FIXED_PRIO_EN
   logic          last_grant;
`endif

   logic          any_req;
   logic          pick1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata;
   logic          sel_oor;

   always_comb begin
      any_req = bus.req0 | bus.req1;
`ifdef GPCFG_ARB_FIXED_PRIO_EN
      pick1   = bus.req1 & ~bus.req0;
`else
      // on a tie, grant whoever did not win last time
      pick1   = bus.req1 & (~bus.req0 | ~last_grant);
`endif
      sel_we    = pick1 ? bus.we1    : bus.we0;
      sel_addr  = pick1 ? bus.addr1  : bus.addr0;
      sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
      sel_oor   = (32'(sel_addr) >= 32'(NUM_REGS));
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state      <= IDLE;
         gnt_id     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         err_pend   <= 1'b0;
         rdata_q    <= '0;
`ifndef GPCFG_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_id    <= pick1;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  err_pend  <= sel_oor;
`ifndef GPCFG_ARB_FIXED_PRIO_EN
                  last_grant <= pick1;
`endif
                  if (sel_oor)
                     state <= DONE;
                  else if (sel_we)
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD:    state <= RWAIT;
            RWAIT: begin
               rdata_q <= bus.mux_rdata;
               state   <= DONE;
            end
            WR:    state <= DONE;
            DONE: begin
               // response fields read as 0 whenever no ack is being given
               rdata_q  <= '0;
               err_pend <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cfg_rd    = (state == RD);
   assign bus.cfg_wr    = (state == WR);
   assign bus.cfg_addr  = lat_addr;
   assign bus.cfg_wdata = lat_wdata;
   assign bus.ack0      = (state == DONE) & ~gnt_id;
   assign bus.ack1      = (state == DONE) &  gnt_id;
   assign bus.rsp_err   = (state == DONE) &  err_pend;
   assign bus.rsp_rdata = rdata_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_gpcfg_access_arb.sv
module tb_gpcfg_access_arb;

   logic hclk = 1'b0;
   logic hresetn = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 hclk = ~hclk;

   gpcfg_access_arb_if #(.AW(10)) a_if ();
   gpcfg_access_arb_if #(.AW(10)) b_if ();

   gpcfg_access_arb #(.NUM_REGS(1024), .AW(10)) dut_a (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (a_if.slave)
   );

   gpcfg_access_arb #(.NUM_REGS(1000), .AW(10)) dut_b (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (b_if.slave)
   );

   // register bank contents seen through the read mux of instance A
   function automatic logic [31:0] bank_a(input logic [9:0] idx);
      case (idx)
         10'd5:   return 32'hDEADBEEF;
         10'd7:   return 32'hA5A55A5A;
         10'd9:   return 32'h0BADF00D;
         default: return 32'h0;
      endcase
   endfunction

   // registered OR-mux: data appears the cycle after valid_rd, else 0
   always @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         a_if.mux_rdata <= '0;
         b_if.mux_rdata <= '0;
      end else begin
         a_if.mux_rdata <= a_if.cfg_rd ? bank_a(a_if.cfg_addr) : 32'h0;
         b_if.mux_rdata <= b_if.cfg_rd ? (32'hC0DE0000 | 32'(b_if.cfg_addr)) : 32'h0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic clear_inputs();
      a_if.req0 = 0; a_if.req1 = 0; a_if.we0 = 0; a_if.we1 = 0;
      a_if.addr0 = '0; a_if.addr1 = '0; a_if.wdata0 = '0; a_if.wdata1 = '0;
      b_if.req0 = 0; b_if.req1 = 0; b_if.we0 = 0; b_if.we1 = 0;
      b_if.addr0 = '0; b_if.addr1 = '0; b_if.wdata0 = '0; b_if.wdata1 = '0;
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      clear_inputs();
      repeat (2) @(posedge hclk);
      #1;
      hresetn = 1'b1;
   endtask

   logic [3:0] exp_order;
   logic       got;
   int         n_ack;
   int         overlap;

   initial begin
`ifdef GPCFG_ARB_FIXED_PRIO_EN
      exp_order = 4'b0000;
`else
      exp_order = 4'b1010;   // bit i = expected grant id of i-th ack
`endif
      clear_inputs();
      hresetn = 1'b0;
      #12;
      // reset state
      chk("rst_ack0",      a_if.ack0, 0);
      chk("rst_ack1",      a_if.ack1, 0);
      chk("rst_cfg_rd",    a_if.cfg_rd, 0);
      chk("rst_cfg_wr",    a_if.cfg_wr, 0);
      chk("rst_busy",      a_if.busy, 0);
      chk("rst_rsp_err",   a_if.rsp_err, 0);
      chk("rst_rsp_rdata", a_if.rsp_rdata, 0);
      chk("rst_cfg_addr",  a_if.cfg_addr, 0);
      chk("rst_cfg_wdata", a_if.cfg_wdata, 0);
      do_reset();

      // read of register 5 by req0
      a_if.req0 = 1; a_if.we0 = 0; a_if.addr0 = 10'd5;
      chk("rd_g0_busy", a_if.busy, 0);
      chk("rd_g0_rd",   a_if.cfg_rd, 0);
      tick();
      chk("rd_g1_rd",   a_if.cfg_rd, 1);
      chk("rd_g1_addr", a_if.cfg_addr, 5);
      chk("rd_g1_wr",   a_if.cfg_wr, 0);
      chk("rd_g1_ack",  a_if.ack0, 0);
      tick();
      chk("rd_g2_rd",   a_if.cfg_rd, 0);
      chk("rd_g2_ack",  a_if.ack0, 0);
      tick();
      chk("rd_g3_ack0", a_if.ack0, 1);
      chk("rd_g3_ack1", a_if.ack1, 0);
      chk("rd_g3_data", a_if.rsp_rdata, 32'hDEADBEEF);
      chk("rd_g3_err",  a_if.rsp_err, 0);
      a_if.req0 = 0;
      tick();
      chk("rd_after_ack",  a_if.ack0, 0);
      chk("rd_after_data", a_if.rsp_rdata, 0);
      chk("rd_after_busy", a_if.busy, 0);

      // field change after grant is ignored
      a_if.req0 = 1; a_if.we0 = 0; a_if.addr0 = 10'd5;
      tick();
      a_if.addr0 = 10'd9;
      chk("fc_rd_addr", a_if.cfg_addr, 5);
      tick();
      chk("fc_rw_addr", a_if.cfg_addr, 5);
      tick();
      chk("fc_ack0", a_if.ack0, 1);
      chk("fc_data", a_if.rsp_rdata, 32'hDEADBEEF);
      a_if.req0 = 0;
      tick();

      // write of 0x3FF by req1
      a_if.req1 = 1; a_if.we1 = 1; a_if.addr1 = 10'h3FF; a_if.wdata1 = 32'h12345678;
      chk("wr_g0_wr", a_if.cfg_wr, 0);
      tick();
      chk("wr_g1_wr",    a_if.cfg_wr, 1);
      chk("wr_g1_rd",    a_if.cfg_rd, 0);
      chk("wr_g1_addr",  a_if.cfg_addr, 10'h3FF);
      chk("wr_g1_wdata", a_if.cfg_wdata, 32'h12345678);
      chk("wr_g1_ack",   a_if.ack1, 0);
      tick();
      chk("wr_g2_ack1", a_if.ack1, 1);
      chk("wr_g2_ack0", a_if.ack0, 0);
      chk("wr_g2_wr",   a_if.cfg_wr, 0);
      chk("wr_g2_rd",   a_if.cfg_rd, 0);
      chk("wr_g2_data", a_if.rsp_rdata, 0);
      a_if.req1 = 0;
      tick();
      chk("wr_after_ack", a_if.ack1, 0);

      // tie from reset, both held for four transactions
      do_reset();
      a_if.req0 = 1; a_if.we0 = 0; a_if.addr0 = 10'd5;
      a_if.req1 = 1; a_if.we1 = 0; a_if.addr1 = 10'd7;
      n_ack = 0;
      overlap = 0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         tick();
         if (a_if.ack0 && a_if.ack1) overlap++;
         if (a_if.ack0 || a_if.ack1) begin
            got = a_if.ack1;
            chk($sformatf("tie_grant%0d", n_ack), got, exp_order[n_ack]);
            chk($sformatf("tie_data%0d", n_ack), a_if.rsp_rdata,
                exp_order[n_ack] ? 32'hA5A55A5A : 32'hDEADBEEF);
            n_ack++;
         end
      end
      a_if.req0 = 0; a_if.req1 = 0;
      chk("tie_acks_seen", n_ack, 4);
      chk("tie_no_overlap", overlap, 0);
      tick();

      // reset in RWAIT, then re-issued read
      do_reset();
      a_if.req0 = 1; a_if.we0 = 0; a_if.addr0 = 10'd5;
      tick();
      tick();
      chk("rs_in_rwait", a_if.busy, 1);
      hresetn = 1'b0;
      #1;
      chk("rs_busy",  a_if.busy, 0);
      chk("rs_rd",    a_if.cfg_rd, 0);
      chk("rs_ack0",  a_if.ack0, 0);
      chk("rs_addr",  a_if.cfg_addr, 0);
      chk("rs_rdata", a_if.rsp_rdata, 0);
      tick();
      chk("rs_hold_ack0", a_if.ack0, 0);
      hresetn = 1'b1;
      tick();
      chk("rs_re_rd", a_if.cfg_rd, 1);
      tick();
      chk("rs_re_noack", a_if.ack0, 0);
      tick();
      chk("rs_re_ack0", a_if.ack0, 1);
      chk("rs_re_data", a_if.rsp_rdata, 32'hDEADBEEF);
      a_if.req0 = 0;
      tick();

      // out of range on NUM_REGS = 1000 instance
      b_if.req0 = 1; b_if.we0 = 0; b_if.addr0 = 10'd1000;
      chk("oor_g0_rd", b_if.cfg_rd, 0);
      tick();
      chk("oor_ack0",  b_if.ack0, 1);
      chk("oor_err",   b_if.rsp_err, 1);
      chk("oor_rdata", b_if.rsp_rdata, 0);
      chk("oor_rd",    b_if.cfg_rd, 0);
      chk("oor_wr",    b_if.cfg_wr, 0);
      b_if.req0 = 0;
      tick();
      chk("oor_after_err", b_if.rsp_err, 0);
      chk("oor_after_ack", b_if.ack0, 0);

      // out-of-range write: no write strobe
      b_if.req0 = 1; b_if.we0 = 1; b_if.addr0 = 10'd1023; b_if.wdata0 = 32'h55AA55AA;
      tick();
      chk("oorw_ack0", b_if.ack0, 1);
      chk("oorw_err",  b_if.rsp_err, 1);
      chk("oorw_wr",   b_if.cfg_wr, 0);
      b_if.req0 = 0;
      tick();

      // last valid index on the same instance reads normally
      b_if.req0 = 1; b_if.we0 = 0; b_if.addr0 = 10'd999;
      tick();
      chk("edge_rd", b_if.cfg_rd, 1);
      tick();
      tick();
      chk("edge_ack0",  b_if.ack0, 1);
      chk("edge_err",   b_if.rsp_err, 0);
      chk("edge_rdata", b_if.rsp_rdata, 32'hC0DE03E7);
      b_if.req0 = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
